// File: rtl/sync_gen.sv
// Rebuilds hsync/vsync from FV/LV pixel timing using a free-running raster whose
// H/V counters are pulled onto the LV/FV rising edges, with a clean-frame lock indicator.
module sync_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_SYNC        = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_SYNC        = 5,
  parameter int unsigned V_BACK_PORCH  = 20,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter bit          SYNC_POL      = 1'b1,
  parameter int unsigned LOCK_FRAMES   = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic fv_i,
  input  logic lv_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic de_o,
  output logic locked_o
);

  localparam int unsigned HT  = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int unsigned VT  = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
  localparam int unsigned HA0 = H_SYNC + H_BACK_PORCH;
  localparam int unsigned VA0 = V_SYNC + V_BACK_PORCH;
  localparam int unsigned HW  = $clog2(HT);
  localparam int unsigned VW  = $clog2(VT);
  localparam int unsigned LW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] HLast    = HW'(HT - 1);
  localparam logic [HW-1:0] HAct0    = HW'(HA0);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_SYNC);
  localparam logic [VW-1:0] VLast    = VW'(VT - 1);
  localparam logic [VW-1:0] VAct0    = VW'(VA0);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_SYNC);
  localparam logic [LW-1:0] LockMax  = LW'(LOCK_FRAMES);

  logic [HW-1:0] hcnt_q, hcnt_d, pos;
  logic [VW-1:0] vcnt_q, vcnt_d, line;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          fv_q, lv_q;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, locked_q, locked_d;
  logic          lv_rise, fv_rise, h_err, v_err;

  always_comb begin
    lv_rise = lv_i & ~lv_q;
    fv_rise = fv_i & ~fv_q;
    // Edges override the free-running position for this cycle and everything after it.
    pos     = lv_rise ? HAct0 : hcnt_q;
    line    = fv_rise ? VAct0 : vcnt_q;
    h_err   = lv_rise & (hcnt_q != HAct0);
    v_err   = fv_rise & (vcnt_q != VAct0);

    hcnt_d = (pos == HLast) ? '0 : pos + 1'b1;
    vcnt_d = line;
    if (pos == HLast) begin
      vcnt_d = (line == VLast) ? '0 : line + 1'b1;
    end

    lock_cnt_d = lock_cnt_q;
    if (h_err || v_err) begin
      lock_cnt_d = '0;
    end else if (fv_rise && (lock_cnt_q != LockMax)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    hsync_d  = (pos < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (line < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
    de_d     = fv_i & lv_i;
    locked_d = (lock_cnt_d == LockMax);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      lock_cnt_q <= '0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      de_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fv_q       <= fv_i;
      lv_q       <= lv_i;
      lock_cnt_q <= lock_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      locked_q   <= locked_d;
    end
  end

  assign hsync_o  = hsync_q;
  assign vsync_o  = vsync_q;
  assign de_o     = de_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_sync_gen.sv
// Bench for sync_gen on a shrunken raster: a linear raster-position model checks both sync
// polarities every cycle, with literal checks for free-run counts, lock and reset behaviour.
module tb_sync_gen;

  localparam int HA = 8, HS = 2, HB = 3, HF = 2;
  localparam int VA = 4, VS = 1, VB = 2, VF = 1;
  localparam int LF = 2;
  localparam int HT = HS + HB + HA + HF;  // 15
  localparam int VT = VS + VB + VA + VF;  // 8
  localparam int HA0 = HS + HB;           // 5
  localparam int VA0 = VS + VB;           // 3
  localparam int TOT = HT * VT;           // 120

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fv = 1'b0;
  logic lv = 1'b0;
  logic h1, v1, d1, l1, h0, v0, d0, l0;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  always #5 clk = ~clk;

  sync_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK_PORCH(HB), .H_FRONT_PORCH(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK_PORCH(VB), .V_FRONT_PORCH(VF),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
  ) u_pos (
    .sys_clk(clk), .sys_rst(rst), .fv_i(fv), .lv_i(lv),
    .hsync_o(h1), .vsync_o(v1), .de_o(d1), .locked_o(l1)
  );

  sync_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK_PORCH(HB), .H_FRONT_PORCH(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK_PORCH(VB), .V_FRONT_PORCH(VF),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) u_neg (
    .sys_clk(clk), .sys_rst(rst), .fv_i(fv), .lv_i(lv),
    .hsync_o(h0), .vsync_o(v0), .de_o(d0), .locked_o(l0)
  );

  // Model: one linear raster position r; h/v are its digits, edges overwrite a digit.
  int r, lk, mh, mv;
  bit mfvq, mlvq, lr, fr, merr;
  bit eh, ev, ed, el;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      r = 0; lk = 0; mfvq = 0; mlvq = 0;
      eh = 0; ev = 0; ed = 0; el = 0;
    end else begin
      mh = r % HT;
      mv = r / HT;
      lr = lv && !mlvq;
      fr = fv && !mfvq;
      merr = (lr && mh != HA0) || (fr && mv != VA0);
      if (lr) mh = HA0;
      if (fr) mv = VA0;
      eh = (mh < HS);
      ev = (mv < VS);
      ed = fv && lv;
      if (merr) lk = 0;
      else if (fr && lk < LF) lk++;
      el = (lk == LF);
      r = (mv * HT + mh + 1) % TOT;
      mfvq = fv;
      mlvq = lv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({h1, v1, d1, l1} !== {eh, ev, ed, el} || {h0, v0, d0, l0} !== {~eh, ~ev, ed, el}) begin
        errors++;
        if (prints < 20) begin
          prints++;
          $display("FAIL model t=%0t got pos=%b%b%b%b neg=%b%b%b%b required pos=%b%b%b%b",
                   $time, h1, v1, d1, l1, h0, v0, d0, l0, eh, ev, ed, el);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input bit f, input bit l);
    fv = f;
    lv = l;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit glitch);
    for (int i = 0; i < n; i++) tick(1'b0, glitch ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // One source frame of 'lines' line periods with 'act' active lines; rst_at >= 0 pulses reset.
  task automatic frame(input int lines, input int act, input int rst_at);
    bit a, fb, lb;
    for (int ln = 0; ln < lines; ln++) begin
      for (int px = 0; px < HT; px++) begin
        a  = (ln >= VA0) && (ln < VA0 + act);
        lb = a && (px >= HA0) && (px < HA0 + HA);
        fb = a && !(ln == VA0 && px < HA0);
        rst = (ln * HT + px == rst_at);
        tick(fb, lb);
      end
    end
    rst = 1'b0;
  endtask

  int hc, vc, hc0, lc;

  initial begin
    do_reset(3);
    chk_en = 1'b1;
    check("rst_hsync_pos", h1, 0);
    check("rst_vsync_pos", v1, 0);
    check("rst_hsync_neg", h0, 1);
    check("rst_de", d1, 0);
    check("rst_locked", l1, 0);

    // Free run: two full rasters.
    hc = 0; vc = 0; hc0 = 0; lc = 0;
    for (int i = 0; i < 2 * TOT; i++) begin
      tick(1'b0, 1'b0);
      if (i == 0) check("first_hsync", h1, 1);
      hc += int'(h1);
      vc += int'(v1);
      hc0 += int'(!h0);
      lc += int'(l1);
    end
    check("free_hsync_cycles", hc, 2 * VT * HS);
    check("free_vsync_cycles", vc, 2 * VS * HT);
    check("free_hsync_neg_cycles", hc0, 2 * VT * HS);
    check("free_locked", lc, 0);

    // Aligned source: raster is back at position 0.
    frame(VT, VA, -1);
    check("aligned_f1_locked", l1, 0);
    frame(VT, VA, -1);
    check("aligned_f2_locked", l1, 1);
    frame(VT, VA, -1);
    check("aligned_f3_locked", l1, 1);

    // Source shifted by 7 clocks: first frame errors, then lock rebuilds.
    idle(7, 1'b0);
    frame(VT, VA, -1);
    check("offset_f1_locked", l1, 0);
    frame(VT, VA, -1);
    check("offset_f2_locked", l1, 0);
    frame(VT, VA, -1);
    check("offset_f3_locked", l1, 1);

    // Short frame: the following frame start lands on the wrong line.
    frame(VT - 2, VA - 2, -1);
    check("short_locked", l1, 1);
    frame(VT, VA, -1);
    check("after_short_f1", l1, 0);
    frame(VT, VA, -1);
    check("after_short_f2", l1, 0);
    frame(VT, VA, -1);
    check("after_short_f3", l1, 1);

    // Reset mid-line while locked.
    frame(VT, VA, VA0 * HT + HA0 + 3);
    do_reset(1);
    check("midrst_hsync", h1, 0);
    check("midrst_de", d1, 0);
    check("midrst_locked", l1, 0);
    frame(VT, VA, -1);
    frame(VT, VA, -1);
    check("relock", l1, 1);

    // Randomized sources: gaps, glitches, short/long frames, occasional resets.
    for (int k = 0; k < 25; k++) begin
      int lines, act, ra;
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20), 1'($urandom_range(0, 1)));
      lines = VT - $urandom_range(0, 2);
      act = lines - VA0 - $urandom_range(0, 1);
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lines * HT - 1) : -1;
      frame(lines, act, ra);
    end
    idle(5, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
